xdma_axi_write_master: RTL and testbench
========================================

# xdma_axi_write_master

AXI4 write master for the XDMA datapath: the write-side counterpart of the burst read master. It accepts a job (byte offset, length in beats), consumes an AXI4-Stream, and splits the data into full-length AXI4 write bursts plus one final partial burst. It tracks outstanding bursts through B responses and pulses `ctrl_done` when the last response returns. It sits between the kernel result stream and the memory-mapped interconnect.

## Interface
- `C_ADDR_WIDTH`, 64: AXI address width.
- `C_DATA_WIDTH`, 32: AXI/stream data width; power of two, ≥8.
- `C_LENGTH_WIDTH`, 32: width of `ctrl_length` (beats).
- `C_BURST_LEN`, 256: max beats per burst.
- `C_LOG_BURST_LEN`, 8: log2(`C_BURST_LEN`).
- `C_MAX_OUTSTANDING`, 3: max AW accepted without a matching B.
- `aclk` in 1: clock.
- `areset` in 1: reset, synchronous, active-high.
- `ctrl_start` in 1: one-cycle job start pulse.
- `ctrl_done` out 1: one-cycle pulse at job completion.
- `ctrl_offset` in C_ADDR_WIDTH: start byte address, burst-aligned; sampled with `ctrl_start`.
- `ctrl_length` in C_LENGTH_WIDTH: job length in beats; sampled with `ctrl_start`.
- `awvalid`/`awready` out/in 1: AW handshake.
- `awaddr` out C_ADDR_WIDTH, `awlen` out 8, `awsize` out 3: burst address, length−1, log2(C_DATA_WIDTH/8).
- `wvalid`/`wready` out/in 1; `wdata` out C_DATA_WIDTH; `wstrb` out C_DATA_WIDTH/8, all ones; `wlast` out 1.
- `bvalid` in 1, `bready` out 1 (constant 1), `bresp` in 2.
- `s_tvalid` in 1, `s_tready` out 1, `s_tdata` in C_DATA_WIDTH: input stream.

## Operation
- Job sizing:
  - full = `ctrl_length[C_LENGTH_WIDTH-1:C_LOG_BURST_LEN]`; partial = low bits ≠ 0.
  - Total bursts = full + partial. Final burst awlen = low bits − 1 if partial, else C_BURST_LEN−1.
  - `ctrl_length`=0 is legal: no AXI or stream traffic; `ctrl_done` pulses at start+2.
- States: IDLE → BUSY on `ctrl_start`; BUSY → IDLE on the final B handshake.
  - `ctrl_start` while BUSY is ignored.
- AW path:
  - `awvalid` asserts when BUSY, AW bursts remain, and outstanding < `C_MAX_OUTSTANDING`.
  - `awvalid`, `awaddr` and `awlen` hold stable until `awready`.
  - `awaddr` advances by C_BURST_LEN·C_DATA_WIDTH/8 per accepted AW, with wrap at 2^C_ADDR_WIDTH.
- W path:
  - W beats are allowed only while at least one accepted AW still has its W burst incomplete (aw_to_w counter > 0).
  - `wvalid` = `s_tvalid` & enable; `s_tready` = `wready` & enable; `wdata` = `s_tdata`.
  - Per-burst beat counter; `wlast` is high on the beat where count = awlen of that burst. The counter resets after `wlast`.
- Counters:
  - Outstanding counter: +1 on AW handshake, −1 on B handshake; a simultaneous increment and decrement leaves it unchanged.
  - aw_to_w counter: +1 on AW handshake, −1 on `wlast` handshake.
- Completion: B counter reaches zero → `ctrl_done` next cycle.

## Timing
- Reset values: `awvalid`=0, `wvalid`=0 (enable 0), `s_tready`=0, `wlast`=0, `ctrl_done`=0, `bready`=1, state IDLE.
- `ctrl_start` at cycle N → job registered at N+1 → earliest `awvalid` at N+2 → earliest W beat at the cycle after the first AW handshake.
- W datapath is combinational pass-through, with zero added latency. Full throughput: 1 beat/cycle once enabled.
- `ctrl_done` is asserted at the cycle after the last B handshake.
- `areset` mid-job:
  - All counters and state clear and outputs return to reset values the next cycle.
  - In-flight AXI transactions are abandoned. The interconnect is reset alongside.

## Configuration
- `XDMA_WR_BRESP_CHECK_EN` defined:
  - Adds output `ctrl_error` (1 bit). It is a sticky OR of `bresp[1]` over all B handshakes of the job.
  - It is valid with `ctrl_done` and cleared on accepted `ctrl_start`.
- Not defined: no `ctrl_error` port, and `bresp` is ignored.

## Structure
- Shared package `xdma_pkg`:
  - AXI response enum (OKAY, EXOKAY, SLVERR, DECERR).
  - Burst size/length localparams and the outstanding-counter width function.
- Sub-module: the existing `xdma_counter` is instantiated for the AW burst, B burst, outstanding and aw_to_w counters. The FSM and W beat counter stay inline.

## Test plan
- Single full burst: offset 0x1000, length 256 → one AW (0x1000, awlen 255), 256 W beats with `wlast` on beat 256, `ctrl_done` one cycle after B.
- Partial tail: offset 0, length 600 → AW 0x000/255, 0x400/255, 0x800/87; `wlast` after beats 256, 512, 600.
- Outstanding limit: length 1280, `bvalid` withheld → exactly 3 AW accepted, `awvalid` low until the first B, then the remaining 2 AW.
- Backpressure: random `s_tvalid` gaps and `wready` toggling on length 300 → 300 beats in order, none dropped or duplicated; the job completes.
- Error flag (macro on): length 512, second B = SLVERR → `ctrl_error`=1 with `ctrl_done`; a new job with OKAY responses ends with `ctrl_error`=0.
- Reset mid-burst: `areset` at beat 100 of 256 → all outputs at reset values the next cycle; a following 256-beat job completes normally.

Source files
------------

// File: rtl/xdma_pkg.sv
// Shared types and helpers for the XDMA AXI masters: response codes, master
// FSM states, AXI field widths and counter sizing.
package xdma_pkg;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } axi_resp_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } wr_state_t;

  localparam int AXI_LEN_WIDTH  = 8;
  localparam int AXI_SIZE_WIDTH = 3;

  // Counter width able to hold 0..max_outstanding inclusive.
  function automatic int outstanding_width(input int max_outstanding);
    return $clog2(max_outstanding + 1);
  endfunction

  function automatic logic [AXI_SIZE_WIDTH-1:0] axi_size(input int data_width);
    return AXI_SIZE_WIDTH'($clog2(data_width / 8));
  endfunction

endpackage

// File: rtl/xdma_counter.sv
// Up/down counter with synchronous load, shared by the XDMA masters for burst
// and outstanding-transaction bookkeeping. Simultaneous incr and decr cancel.
module xdma_counter #(
  parameter int C_WIDTH = 8
) (
  input  logic               aclk,
  input  logic               areset,
  input  logic               load,
  input  logic [C_WIDTH-1:0] load_value,
  input  logic               incr,
  input  logic               decr,
  output logic [C_WIDTH-1:0] count,
  output logic               is_zero
);

  always_ff @(posedge aclk) begin
    if (areset) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (incr && !decr) begin
      count <= count + C_WIDTH'(1);
    end else if (decr && !incr) begin
      count <= count - C_WIDTH'(1);
    end
  end

  assign is_zero = (count == '0);

endmodule

// File: rtl/xdma_axi_write_master.sv
// AXI4 write master: splits a stream job into full bursts plus one partial tail.
// Optional macro XDMA_WR_BRESP_CHECK_EN adds the sticky ctrl_error output.
//
// Handshakes: a transfer happens on a rising aclk edge where valid and ready
// are both high; awvalid/awaddr/awlen never change while awvalid waits for
// awready, and W/stream signals are a combinational pass-through gated by enable.
module xdma_axi_write_master
  import xdma_pkg::*;
#(
  parameter int C_ADDR_WIDTH      = 64,
  parameter int C_DATA_WIDTH      = 32,
  parameter int C_LENGTH_WIDTH    = 32,
  parameter int C_BURST_LEN       = 256,
  parameter int C_LOG_BURST_LEN   = 8,
  parameter int C_MAX_OUTSTANDING = 3
) (
  input  logic                          aclk,
  input  logic                          areset,
  input  logic                          ctrl_start,
  output logic                          ctrl_done,
  input  logic [C_ADDR_WIDTH-1:0]       ctrl_offset,
  input  logic [C_LENGTH_WIDTH-1:0]     ctrl_length,
  output logic                          awvalid,
  input  logic                          awready,
  output logic [C_ADDR_WIDTH-1:0]       awaddr,
  output logic [AXI_LEN_WIDTH-1:0]      awlen,
  output logic [AXI_SIZE_WIDTH-1:0]     awsize,
  output logic                          wvalid,
  input  logic                          wready,
  output logic [C_DATA_WIDTH-1:0]       wdata,
  output logic [C_DATA_WIDTH/8-1:0]     wstrb,
  output logic                          wlast,
  input  logic                          bvalid,
  output logic                          bready,
  input  logic [1:0]                    bresp,
  input  logic                          s_tvalid,
  output logic                          s_tready,
  input  logic [C_DATA_WIDTH-1:0]       s_tdata,
`ifdef XDMA_WR_BRESP_CHECK_EN
  output logic                          ctrl_error,
`endif
  output wr_state_t                     dbg_state
);

  localparam int OST_W = outstanding_width(C_MAX_OUTSTANDING);
  localparam logic [C_ADDR_WIDTH-1:0] BURST_BYTES =
    C_ADDR_WIDTH'(C_BURST_LEN * (C_DATA_WIDTH / 8));
  localparam logic [AXI_LEN_WIDTH-1:0] FULL_AWLEN = AXI_LEN_WIDTH'(C_BURST_LEN - 1);

  wr_state_t                   state;
  logic [AXI_LEN_WIDTH-1:0]    last_awlen;
  logic [AXI_LEN_WIDTH-1:0]    w_beat;
  logic [C_LENGTH_WIDTH-1:0]   aw_left, b_left;
  logic                        aw_left_zero, b_left_zero;
  logic [OST_W-1:0]            ost, aw_to_w;
  logic                        aw_to_w_zero;
  logic                        unused_ost_zero;

  logic start_ok, aw_hs, w_hs, b_hs, wlast_hs;
  logic w_en, w_final;
  logic [AXI_LEN_WIDTH-1:0] cur_w_awlen;

  assign start_ok = ctrl_start && (state == ST_IDLE);
  assign aw_hs    = awvalid && awready;
  assign w_hs     = wvalid && wready;
  assign b_hs     = bvalid && bready && (state == ST_BUSY);
  assign wlast_hs = w_hs && wlast;

  // Job sizing from the inputs sampled with ctrl_start.
  logic [C_LOG_BURST_LEN-1:0]  job_low;
  logic                        job_partial;
  logic [C_LENGTH_WIDTH-1:0]   job_bursts;
  logic [AXI_LEN_WIDTH-1:0]    job_last_awlen;

  assign job_low        = ctrl_length[C_LOG_BURST_LEN-1:0];
  assign job_partial    = |job_low;
  assign job_bursts     = (ctrl_length >> C_LOG_BURST_LEN) + C_LENGTH_WIDTH'(job_partial);
  assign job_last_awlen = job_partial ? AXI_LEN_WIDTH'(job_low - 1'b1) : FULL_AWLEN;

  xdma_counter #(.C_WIDTH(C_LENGTH_WIDTH)) u_aw_bursts (
    .aclk(aclk), .areset(areset), .load(start_ok), .load_value(job_bursts),
    .incr(1'b0), .decr(aw_hs), .count(aw_left), .is_zero(aw_left_zero)
  );

  xdma_counter #(.C_WIDTH(C_LENGTH_WIDTH)) u_b_bursts (
    .aclk(aclk), .areset(areset), .load(start_ok), .load_value(job_bursts),
    .incr(1'b0), .decr(b_hs), .count(b_left), .is_zero(b_left_zero)
  );

  xdma_counter #(.C_WIDTH(OST_W)) u_outstanding (
    .aclk(aclk), .areset(areset), .load(1'b0), .load_value('0),
    .incr(aw_hs), .decr(b_hs), .count(ost), .is_zero(unused_ost_zero)
  );

  xdma_counter #(.C_WIDTH(OST_W)) u_aw_to_w (
    .aclk(aclk), .areset(areset), .load(1'b0), .load_value('0),
    .incr(aw_hs), .decr(wlast_hs), .count(aw_to_w), .is_zero(aw_to_w_zero)
  );

  // The W burst in progress is the job's last one only once every AW is out
  // and it is the sole burst still waiting for data.
  assign w_en        = !aw_to_w_zero;
  assign w_final     = aw_left_zero && (aw_to_w == OST_W'(1));
  assign cur_w_awlen = w_final ? last_awlen : FULL_AWLEN;

  assign wvalid   = s_tvalid && w_en;
  assign s_tready = wready && w_en;
  assign wdata    = s_tdata;
  assign wstrb    = '1;
  assign wlast    = w_en && (w_beat == cur_w_awlen);
  assign bready   = 1'b1;
  assign awsize   = axi_size(C_DATA_WIDTH);
  assign dbg_state = state;

  always_ff @(posedge aclk) begin
    if (areset) begin
      state      <= ST_IDLE;
      awvalid    <= 1'b0;
      awaddr     <= '0;
      awlen      <= '0;
      last_awlen <= '0;
      w_beat     <= '0;
      ctrl_done  <= 1'b0;
    end else begin
      ctrl_done <= 1'b0;

      if (w_hs) begin
        w_beat <= wlast ? '0 : w_beat + AXI_LEN_WIDTH'(1);
      end

      if (aw_hs) begin
        awvalid <= 1'b0;
        awaddr  <= awaddr + BURST_BYTES;
      end else if (!awvalid && (state == ST_BUSY) && !aw_left_zero &&
                   (ost < OST_W'(C_MAX_OUTSTANDING))) begin
        awvalid <= 1'b1;
        awlen   <= (aw_left == C_LENGTH_WIDTH'(1)) ? last_awlen : FULL_AWLEN;
      end

      case (state)
        ST_IDLE: begin
          if (ctrl_start) begin
            state      <= ST_BUSY;
            awaddr     <= ctrl_offset;
            last_awlen <= job_last_awlen;
          end
        end
        ST_BUSY: begin
          // Zero-length jobs have no B to wait for and finish straight away.
          if (b_left_zero || (b_hs && (b_left == C_LENGTH_WIDTH'(1)))) begin
            state     <= ST_IDLE;
            ctrl_done <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef XDMA_WR_BRESP_CHECK_EN
  axi_resp_t resp;
  assign resp = axi_resp_t'(bresp);

  always_ff @(posedge aclk) begin
    if (areset || start_ok) begin
      ctrl_error <= 1'b0;
    end else if (b_hs && (resp == RESP_SLVERR || resp == RESP_DECERR)) begin
      ctrl_error <= 1'b1;
    end
  end
`else
  logic unused_bresp;
  assign unused_bresp = ^bresp;
`endif

endmodule

// File: tb/tb_xdma_axi_write_master.sv
// Directed bench for xdma_axi_write_master: an AXI slave / stream source model
// on the falling edge, hand-computed burst tables, one check task.
module tb_xdma_axi_write_master;
  import xdma_pkg::*;

  localparam int BL = 256;

  logic        aclk = 1'b0;
  logic        areset = 1'b1;
  logic        ctrl_start = 1'b0;
  logic        ctrl_done;
  logic [63:0] ctrl_offset = '0;
  logic [31:0] ctrl_length = '0;
  logic        awvalid;
  logic        awready = 1'b0;
  logic [63:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic        wvalid;
  logic        wready = 1'b0;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        bvalid = 1'b0;
  logic        bready;
  logic [1:0]  bresp = 2'b00;
  logic        s_tvalid = 1'b0;
  logic        s_tready;
  logic [31:0] s_tdata = '0;
`ifdef XDMA_WR_BRESP_CHECK_EN
  logic        ctrl_error;
  logic        err_at_done = 1'b0;
`endif
  wr_state_t   dbg_state;

  xdma_axi_write_master dut (
    .aclk(aclk), .areset(areset),
    .ctrl_start(ctrl_start), .ctrl_done(ctrl_done),
    .ctrl_offset(ctrl_offset), .ctrl_length(ctrl_length),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
    .bvalid(bvalid), .bready(bready), .bresp(bresp),
    .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(s_tdata),
`ifdef XDMA_WR_BRESP_CHECK_EN
    .ctrl_error(ctrl_error),
`endif
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 aclk = ~aclk;

  int cyc = 0;
  always @(posedge aclk) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------- job requests (main-owned) ----------------
  int          job_id = 0;
  int          job_len = 0;
  logic [7:0]  job_tag = '0;
  int          start_cyc = 0;
  bit          s_gaps = 0, w_bp = 0, aw_bp = 0, b_hold = 0;
  int          b_err_idx = -1;

  // ---------------- slave / source model state (model-owned) ----------------
  int          seen_id = 0;
  logic [63:0] aw_addr_q[$];
  logic [7:0]  aw_len_q[$];
  logic [31:0] exp_q[$];
  int src_idx = 0, beats = 0, wlast_n = 0, data_err = 0, wlast_err = 0;
  int order_err = 0, hs_err = 0, ost_err = 0, pending_b = 0, b_n = 0, done_n = 0;
  int first_awv_cyc = -1, first_awhs_cyc = -1, first_w_cyc = -1;
  int last_b_cyc = -1, done_cyc = -1;
  bit s_hold = 0;

  always @(negedge aclk) begin
    if (job_id != seen_id) begin
      seen_id = job_id;
      aw_addr_q.delete(); aw_len_q.delete(); exp_q.delete();
      for (int i = 0; i < job_len; i++) exp_q.push_back({job_tag, 24'(i)});
      src_idx = 0; beats = 0; wlast_n = 0; data_err = 0; wlast_err = 0;
      order_err = 0; hs_err = 0; ost_err = 0; b_n = 0; done_n = 0; s_hold = 0;
      first_awv_cyc = -1; first_awhs_cyc = -1; first_w_cyc = -1;
      last_b_cyc = -1; done_cyc = -1;
    end
    if (areset) begin
      awready = 1'b0; wready = 1'b0; s_tvalid = 1'b0; bvalid = 1'b0;
      bresp = RESP_OKAY; pending_b = 0; s_hold = 0;
    end else begin
      awready = aw_bp ? 1'($urandom_range(0, 1)) : 1'b1;
      wready  = w_bp ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (!s_hold) begin
        s_tvalid = (src_idx < job_len) && (!s_gaps || ($urandom_range(0, 2) != 0));
        s_tdata  = {job_tag, 24'(src_idx)};
      end
      bvalid = (pending_b > 0) && !b_hold;
      bresp  = (b_n == b_err_idx) ? RESP_SLVERR : RESP_OKAY;
      #1;
      if (awvalid && first_awv_cyc < 0) first_awv_cyc = cyc;
      if (wvalid && wready) begin
        beats++;
        if (((beats - 1) / BL) >= aw_addr_q.size()) order_err++;
        if (exp_q.size() == 0) data_err++;
        else if (wdata !== exp_q.pop_front()) data_err++;
        if (wlast !== ((beats % BL == 0) || (beats == job_len))) wlast_err++;
        if (wlast) begin wlast_n++; pending_b++; end
        if (first_w_cyc < 0) first_w_cyc = cyc;
      end
      if ((wvalid && wready) != (s_tvalid && s_tready)) hs_err++;
      if (s_tvalid && s_tready) src_idx++;
      s_hold = s_tvalid && !s_tready;
      if (awvalid && awready) begin
        if (aw_addr_q.size() - b_n >= 3) ost_err++;
        aw_addr_q.push_back(awaddr);
        aw_len_q.push_back(awlen);
        if (first_awhs_cyc < 0) first_awhs_cyc = cyc;
      end
      if (bvalid && bready) begin pending_b--; b_n++; last_b_cyc = cyc; end
      if (ctrl_done) begin
        done_n++; done_cyc = cyc;
`ifdef XDMA_WR_BRESP_CHECK_EN
        err_at_done = ctrl_error;
`endif
      end
    end
  end

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(negedge aclk);
    #2;
  endtask

  task automatic start_job(input logic [63:0] off, input int len, input logic [7:0] tag);
    job_len = len; job_tag = tag; job_id++;
    ctrl_offset = off; ctrl_length = 32'(len); ctrl_start = 1'b1;
    start_cyc = cyc;
    tick();
    ctrl_start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    for (int i = 0; i < budget && done_n == 0; i++) tick();
    check({tag, "_done"}, done_n, 1);
    repeat (3) tick();
    check({tag, "_done_once"}, done_n, 1);
  endtask

  task automatic finish_job(input string tag, input int len, input int bursts);
    check({tag, "_beats"}, beats, len);
    check({tag, "_data"}, data_err, 0);
    check({tag, "_wlast_pos"}, wlast_err, 0);
    check({tag, "_wlast_n"}, wlast_n, bursts);
    check({tag, "_aw_n"}, aw_addr_q.size(), bursts);
    check({tag, "_w_before_aw"}, order_err, 0);
    check({tag, "_s_w_hs"}, hs_err, 0);
    check({tag, "_outstanding"}, ost_err, 0);
    check({tag, "_b_n"}, b_n, bursts);
    if (bursts > 0) check({tag, "_done_after_b"}, done_cyc - last_b_cyc, 1);
    check({tag, "_state_idle"}, dbg_state, ST_IDLE);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_awvalid"}, awvalid, 0);
    check({tag, "_wvalid"}, wvalid, 0);
    check({tag, "_s_tready"}, s_tready, 0);
    check({tag, "_wlast"}, wlast, 0);
    check({tag, "_ctrl_done"}, ctrl_done, 0);
    check({tag, "_bready"}, bready, 1);
    check({tag, "_state"}, dbg_state, ST_IDLE);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    areset = 1'b1;
    repeat (3) tick();
    check_reset_outputs("reset");
    check("awsize", awsize, 3'd2);
    check("wstrb", wstrb, 4'hF);
    areset = 1'b0;
    tick();

    // Single full burst.
    start_job(64'h1000, 256, 8'h01);
    wait_done("full", 1000);
    finish_job("full", 256, 1);
    check("full_addr0", aw_addr_q[0], 64'h1000);
    check("full_len0", aw_len_q[0], 8'd255);
    check("full_awvalid_lat", first_awv_cyc - start_cyc, 2);
    check("full_first_w_lat", first_w_cyc - first_awhs_cyc, 1);

    // Partial tail, plus a start pulse mid-job that must be ignored.
    start_job(64'h0, 600, 8'h02);
    repeat (50) tick();
    ctrl_offset = 64'hDEAD_0000; ctrl_length = 32'd5; ctrl_start = 1'b1;
    tick();
    ctrl_start = 1'b0;
    wait_done("tail", 2000);
    finish_job("tail", 600, 3);
    check("tail_addr0", aw_addr_q[0], 64'h000);
    check("tail_addr1", aw_addr_q[1], 64'h400);
    check("tail_addr2", aw_addr_q[2], 64'h800);
    check("tail_len1", aw_len_q[1], 8'd255);
    check("tail_len2", aw_len_q[2], 8'd87);

    // Outstanding limit with B withheld.
    b_hold = 1;
    start_job(64'h2000, 1280, 8'h03);
    repeat (1000) tick();
    check("ost_aw_held", aw_addr_q.size(), 3);
    check("ost_awvalid_low", awvalid, 0);
    check("ost_beats_held", beats, 768);
    check("ost_state_busy", dbg_state, ST_BUSY);
    b_hold = 0;
    wait_done("ost", 1500);
    finish_job("ost", 1280, 5);
    check("ost_addr3", aw_addr_q[3], 64'h2C00);
    check("ost_addr4", aw_addr_q[4], 64'h3000);
    check("ost_len4", aw_len_q[4], 8'd255);

    // Backpressure on every channel.
    aw_bp = 1; w_bp = 1; s_gaps = 1;
    start_job(64'h4_0000, 300, 8'h04);
    wait_done("bp", 3000);
    finish_job("bp", 300, 2);
    check("bp_addr1", aw_addr_q[1], 64'h4_0400);
    check("bp_len1", aw_len_q[1], 8'd43);
    aw_bp = 0; w_bp = 0; s_gaps = 0;

    // Zero-length job.
    start_job(64'h5000, 0, 8'h05);
    wait_done("zero", 20);
    check("zero_done_lat", done_cyc - start_cyc, 2);
    finish_job("zero", 0, 0);

`ifdef XDMA_WR_BRESP_CHECK_EN
    b_err_idx = 1;
    start_job(64'h6000, 512, 8'h06);
    wait_done("err", 2000);
    finish_job("err", 512, 2);
    check("err_flag_set", err_at_done, 1);
    b_err_idx = -1;
    start_job(64'h7000, 256, 8'h07);
    wait_done("err_clr", 1000);
    check("err_flag_clear", err_at_done, 0);
`endif

    // Reset mid-burst, then a clean job.
    start_job(64'h8000, 256, 8'h08);
    for (int i = 0; i < 600 && beats < 100; i++) tick();
    check("rst_reach_beat100", beats >= 100, 1);
    areset = 1'b1;
    tick();
    check_reset_outputs("midrst");
    tick();
    areset = 1'b0;
    tick();
    start_job(64'h9000, 256, 8'h09);
    wait_done("post_rst", 1000);
    finish_job("post_rst", 256, 1);
    check("post_rst_addr0", aw_addr_q[0], 64'h9000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
